// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states,
// instruction classes and the select/trap encodings driven onto the datapath.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_R       = 7'b0110011;
  localparam logic [6:0] OPC_I_ARITH = 7'b0010011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;

  typedef enum logic [2:0] {
    RESET_IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_e;

  typedef enum logic [3:0] {
    CLS_R,
    CLS_I_ARITH,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC,
    CLS_NONE
  } instClass_e;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [1:0] CAUSE_NONE       = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL    = 2'd1;
  localparam logic [1:0] CAUSE_FETCH_TOUT = 2'd2;
  localparam logic [1:0] CAUSE_DATA_TOUT  = 2'd3;

  // funct3[2] picks the less-than compare over equality; funct3[0] inverts it.
  function automatic logic branchTaken(input logic [2:0] funct3,
                                       input logic       brEq,
                                       input logic       brLt);
    return (funct3[2] ? brLt : brEq) ^ funct3[0];
  endfunction

endpackage

// File: rtl/rv_decode.sv
// Combinational RV32I decoder: classifies the instruction register contents,
// flags illegal encodings and produces the immediate format and ALU operation.
module rv_decode
  import rv_ctrl_pkg::*;
(
  input  logic [31:0] i_inst,
  output instClass_e  o_class,
  output logic        o_illegal,
  output logic [2:0]  o_immSel,
  output logic [3:0]  o_aluSel
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_unusedFields;

  assign w_opcode       = i_inst[6:0];
  assign w_funct3       = i_inst[14:12];
  assign w_funct7       = i_inst[31:25];
  assign w_unusedFields = ^{i_inst[24:15], i_inst[11:7]};

  always_comb begin
    o_class   = CLS_NONE;
    o_illegal = 1'b1;
    o_immSel  = IMM_I;
    o_aluSel  = 4'b0000;
    case (w_opcode)
      OPC_R: begin
        o_class   = CLS_R;
        // The alternate funct7 only exists for SUB and SRA.
        o_illegal = !((w_funct7 == 7'b0000000) ||
                      ((w_funct7 == 7'b0100000) &&
                       ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
        o_aluSel  = {i_inst[30], w_funct3};
      end
      OPC_I_ARITH: begin
        o_class   = CLS_I_ARITH;
        o_illegal = 1'b0;
        o_aluSel  = (w_funct3 == 3'b101) ? {i_inst[30], w_funct3} : {1'b0, w_funct3};
      end
      OPC_LOAD: begin
        o_class   = CLS_LOAD;
        o_illegal = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
      end
      OPC_STORE: begin
        o_class   = CLS_STORE;
        o_illegal = (w_funct3 > 3'b010);
        o_immSel  = IMM_S;
      end
      OPC_BRANCH: begin
        o_class   = CLS_BRANCH;
        o_illegal = (w_funct3[2:1] == 2'b01);
        o_immSel  = IMM_B;
      end
      OPC_JAL: begin
        o_class   = CLS_JAL;
        o_illegal = 1'b0;
        o_immSel  = IMM_J;
      end
      OPC_JALR: begin
        o_class   = CLS_JALR;
        o_illegal = 1'b0;
      end
      OPC_LUI: begin
        o_class   = CLS_LUI;
        o_illegal = 1'b0;
        o_immSel  = IMM_U;
      end
      OPC_AUIPC: begin
        o_class   = CLS_AUIPC;
        o_illegal = 1'b0;
        o_immSel  = IMM_U;
      end
      default: begin
        o_class   = CLS_NONE;
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I controller: sequences fetch/decode/execute/memory/write-back
// over a shared datapath and a handshaked memory port with a bounded wait.
module multicycle_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] inst,
  input  logic            BrEq,
  input  logic            BrLt,
  input  logic            mem_ack,
  output logic            mem_req,
  output logic            IRWEn,
  output logic            PCWEn,
  output logic            PCSel,
  output logic            RegWEn,
  output logic            BrUn,
  output logic            ASel,
  output logic            BSel,
  output logic            MemRW,
  output logic [1:0]      WBSel,
  output logic [1:0]      WSel,
  output logic [2:0]      RSel,
  output logic [2:0]      ImmSel,
  output logic [3:0]      ALUSel,
  output logic            trap,
  output logic [1:0]      trap_cause
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_e     r_state;
  state_e     w_nextState;
  logic [CW-1:0] r_waitCount;
  logic [1:0] r_trapCause;
  logic [1:0] w_trapCauseNext;

  instClass_e w_class;
  logic       w_illegal;
  logic [2:0] w_immSel;
  logic [3:0] w_aluSel;
  logic [2:0] w_funct3;
  logic       w_decoded;
  logic       w_waiting;
  logic       w_timeoutHit;
  logic       w_unusedInst;

  rv_decode u_decode (
    .i_inst    (inst[31:0]),
    .o_class   (w_class),
    .o_illegal (w_illegal),
    .o_immSel  (w_immSel),
    .o_aluSel  (w_aluSel)
  );

  assign w_funct3     = inst[14:12];
  assign w_unusedInst = ^inst;
  assign w_decoded    = r_state inside {DECODE, EXEC, MEM, WB};
  assign w_waiting    = (r_state == FETCH) || (r_state == MEM);
  assign w_timeoutHit = (r_waitCount == CW'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RESET_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Any state change restarts the wait count, so each FETCH/MEM entry starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waitCount <= '0;
    end else if ((w_nextState != r_state) || !w_waiting) begin
      r_waitCount <= '0;
    end else begin
      r_waitCount <= r_waitCount + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trapCause <= CAUSE_NONE;
    end else if ((r_state != TRAP) && (w_nextState == TRAP)) begin
      r_trapCause <= w_trapCauseNext;
    end
  end

  always_comb begin
    w_nextState     = r_state;
    w_trapCauseNext = CAUSE_NONE;
    mem_req         = 1'b0;
    IRWEn           = 1'b0;
    PCWEn           = 1'b0;
    PCSel           = 1'b0;
    RegWEn          = 1'b0;
    BrUn            = 1'b0;
    ASel            = 1'b0;
    BSel            = 1'b0;
    MemRW           = 1'b0;
    WBSel           = WB_MEM;
    WSel            = 2'b00;
    RSel            = 3'b000;
    ImmSel          = IMM_I;
    ALUSel          = 4'b0000;

    // Datapath selects follow the decoded instruction from DECODE through WB.
    if (w_decoded) begin
      ImmSel = w_immSel;
      ALUSel = w_aluSel;
      ASel   = (w_class == CLS_BRANCH) || (w_class == CLS_JAL) || (w_class == CLS_AUIPC);
      BSel   = (w_class != CLS_R);
      BrUn   = (w_class == CLS_BRANCH) && w_funct3[1];
      case (w_class)
        CLS_LOAD:          WBSel = WB_MEM;
        CLS_JAL, CLS_JALR: WBSel = WB_PC4;
        CLS_LUI:           WBSel = WB_IMM;
        default:           WBSel = WB_ALU;
      endcase
    end

    case (r_state)
      RESET_IDLE: begin
        w_nextState = FETCH;
      end
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          IRWEn       = 1'b1;
          w_nextState = DECODE;
        end else if (w_timeoutHit) begin
          w_nextState     = TRAP;
          w_trapCauseNext = CAUSE_FETCH_TOUT;
        end
      end
      DECODE: begin
        if (w_illegal) begin
          w_nextState     = TRAP;
          w_trapCauseNext = CAUSE_ILLEGAL;
        end else begin
          w_nextState = EXEC;
        end
      end
      EXEC: begin
        if (w_class == CLS_BRANCH) begin
          PCWEn       = 1'b1;
          PCSel       = branchTaken(w_funct3, BrEq, BrLt);
          w_nextState = FETCH;
        end else if ((w_class == CLS_LOAD) || (w_class == CLS_STORE)) begin
          w_nextState = MEM;
        end else begin
          w_nextState = WB;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        MemRW   = (w_class == CLS_STORE);
        RSel    = (w_class == CLS_LOAD) ? w_funct3 : 3'b000;
        WSel    = (w_class == CLS_STORE) ? w_funct3[1:0] : 2'b00;
        if (mem_ack) begin
          if (w_class == CLS_STORE) begin
            PCWEn       = 1'b1;
            w_nextState = FETCH;
          end else begin
            w_nextState = WB;
          end
        end else if (w_timeoutHit) begin
          w_nextState     = TRAP;
          w_trapCauseNext = CAUSE_DATA_TOUT;
        end
      end
      WB: begin
        RegWEn      = 1'b1;
        PCWEn       = 1'b1;
        PCSel       = (w_class == CLS_JAL) || (w_class == CLS_JALR);
        RSel        = (w_class == CLS_LOAD) ? w_funct3 : 3'b000;
        w_nextState = FETCH;
      end
      TRAP: begin
        w_nextState = TRAP;
      end
      default: begin
        w_nextState = RESET_IDLE;
      end
    endcase
  end

  assign trap       = (r_state == TRAP);
  assign trap_cause = r_trapCause;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench for multicycle_control_unit: per-instruction
// cycle counts, enable pulses and select values against a mnemonic-level model.
module tb_multicycle_control_unit;

  localparam int TB_TIMEOUT = 6;

  localparam int K_R     = 0;
  localparam int K_I     = 1;
  localparam int K_LD    = 2;
  localparam int K_ST    = 3;
  localparam int K_BR    = 4;
  localparam int K_JAL   = 5;
  localparam int K_JALR  = 6;
  localparam int K_LUI   = 7;
  localparam int K_AUIPC = 8;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst;
  logic        BrEq, BrLt, mem_ack;
  logic        mem_req, IRWEn, PCWEn, PCSel, RegWEn, BrUn, ASel, BSel, MemRW, trap;
  logic [1:0]  WBSel, WSel, trap_cause;
  logic [2:0]  RSel, ImmSel;
  logic [3:0]  ALUSel;
  logic [25:0] allOutputs;

  int checkCount;
  int errorCount;

  multicycle_control_unit #(.XLEN(32), .MEM_TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .BrEq(BrEq), .BrLt(BrLt),
    .mem_ack(mem_ack), .mem_req(mem_req), .IRWEn(IRWEn), .PCWEn(PCWEn),
    .PCSel(PCSel), .RegWEn(RegWEn), .BrUn(BrUn), .ASel(ASel), .BSel(BSel),
    .MemRW(MemRW), .WBSel(WBSel), .WSel(WSel), .RSel(RSel), .ImmSel(ImmSel),
    .ALUSel(ALUSel), .trap(trap), .trap_cause(trap_cause)
  );

  assign allOutputs = {mem_req, IRWEn, PCWEn, PCSel, RegWEn, BrUn, ASel, BSel, MemRW, trap,
                       WBSel, WSel, RSel, ImmSel, ALUSel, trap_cause};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Leaves the bench at posedge+1 of the first FETCH cycle.
  task automatic applyReset();
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    #1;
    checkOutput("reset.outputs", 32'(allOutputs), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #3;
    checkOutput("reset.idleNoReq", 32'(mem_req), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("reset.fetchReq2ndCycle", 32'(mem_req), 32'h1);
  endtask

  function automatic logic [31:0] genInst(input int kind);
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7, opc;
    logic [2:0] ldF3 [5];
    logic [2:0] brF3 [6];
    ldF3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    brF3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    f3  = 3'($urandom);
    f7  = 7'($urandom);
    opc = 7'b0;
    case (kind)
      K_R: begin
        opc = 7'b0110011;
        f7  = (((f3 == 3'd0) || (f3 == 3'd5)) && ($urandom_range(0, 1) == 1)) ? 7'b0100000 : 7'b0;
      end
      K_I: begin
        opc = 7'b0010011;
        if (f3 == 3'd1) f7 = 7'b0;
        else if (f3 == 3'd5) f7 = {1'b0, 1'($urandom), 5'b0};
      end
      K_LD:    begin opc = 7'b0000011; f3 = ldF3[$urandom_range(0, 4)]; end
      K_ST:    begin opc = 7'b0100011; f3 = 3'($urandom_range(0, 2)); end
      K_BR:    begin opc = 7'b1100011; f3 = brF3[$urandom_range(0, 5)]; end
      K_JAL:   opc = 7'b1101111;
      K_JALR:  begin opc = 7'b1100111; f3 = 3'd0; end
      K_LUI:   opc = 7'b0110111;
      K_AUIPC: opc = 7'b0010111;
      default: opc = 7'b0;
    endcase
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  // Runs one legal instruction from FETCH entry; fW/mW are wait cycles before mem_ack.
  task automatic applyStimulus(input string name, input int kind, input logic [31:0] ins,
                               input int fW, input int mW, input logic eq, input logic lt);
    int cyc = 0, reqCyc = 0, irCnt = 0, pcwCnt = 0, regwCnt = 0, phase = 0, waitCnt = 0;
    int expCycles, expReq;
    logic pcSelObs = 0, brUnObs = 0, aObs = 0, bObs = 0, prevIR = 0, done = 0;
    logic memRwFetch = 0, memRwMem = 0, taken;
    logic [1:0] wbObs = 0, wselObs = 0, expWb;
    logic [2:0] immObs = 0, rselObs = 0, f3, expImm;
    logic [3:0] aluObs = 0, expAlu;
    logic ldst, expPcSel;
    inst = ins;
    BrEq = eq;
    BrLt = lt;
    while (!done && cyc < 80) begin
      if (mem_req) mem_ack = (waitCnt == ((phase == 0) ? fW : mW));
      else         mem_ack = 1'($urandom_range(0, 1));
      #4;
      cyc++;
      if (mem_req) begin
        reqCyc++;
        if (phase == 0) memRwFetch = memRwFetch | MemRW;
        else begin memRwMem = MemRW; rselObs = RSel; wselObs = WSel; end
      end
      if (prevIR) begin immObs = ImmSel; aObs = ASel; bObs = BSel; end
      prevIR = IRWEn;
      if (IRWEn) irCnt++;
      if (PCWEn) begin pcwCnt++; pcSelObs = PCSel; brUnObs = BrUn; done = 1; end
      if (RegWEn) begin regwCnt++; wbObs = WBSel; aluObs = ALUSel; end
      if (trap) done = 1;
      if (mem_req) begin
        if (mem_ack) begin phase++; waitCnt = 0; end
        else waitCnt++;
      end
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
    checkOutput($sformatf("%s.finished", name), 32'(done), 32'h1);

    f3   = ins[14:12];
    ldst = (kind == K_LD) || (kind == K_ST);
    case (f3)
      3'b000:         taken = eq;
      3'b001:         taken = !eq;
      3'b100, 3'b110: taken = lt;
      3'b101, 3'b111: taken = !lt;
      default:        taken = 1'b0;
    endcase
    expCycles = (kind == K_BR) ? 3 : (kind == K_LD) ? 5 : 4;
    expCycles = expCycles + fW + (ldst ? mW : 0);
    expReq    = fW + 1 + (ldst ? mW + 1 : 0);
    expPcSel  = (kind == K_BR) ? taken : ((kind == K_JAL) || (kind == K_JALR));
    expWb     = (kind == K_LD) ? 2'd0 : ((kind == K_JAL) || (kind == K_JALR)) ? 2'd2 :
                (kind == K_LUI) ? 2'd3 : 2'd1;
    if (kind == K_R) expAlu = {ins[30], f3};
    else if (kind == K_I) expAlu = (f3 == 3'b101) ? {ins[30], f3} : {1'b0, f3};
    else expAlu = 4'b0000;
    case (kind)
      K_ST:           expImm = 3'd1;
      K_BR:           expImm = 3'd2;
      K_LUI, K_AUIPC: expImm = 3'd3;
      K_JAL:          expImm = 3'd4;
      default:        expImm = 3'd0;
    endcase

    checkOutput($sformatf("%s.cycles", name), 32'(cyc), 32'(expCycles));
    checkOutput($sformatf("%s.reqCycles", name), 32'(reqCyc), 32'(expReq));
    checkOutput($sformatf("%s.irwenPulses", name), 32'(irCnt), 32'h1);
    checkOutput($sformatf("%s.pcwenPulses", name), 32'(pcwCnt), 32'h1);
    checkOutput($sformatf("%s.pcSel", name), 32'(pcSelObs), 32'(expPcSel));
    checkOutput($sformatf("%s.fetchMemRW", name), 32'(memRwFetch), 32'h0);
    checkOutput($sformatf("%s.aSel", name), 32'(aObs),
                32'((kind == K_BR) || (kind == K_JAL) || (kind == K_AUIPC)));
    checkOutput($sformatf("%s.bSel", name), 32'(bObs), 32'(kind != K_R));
    if (kind != K_R)
      checkOutput($sformatf("%s.immSel", name), 32'(immObs), 32'(expImm));
    if ((kind == K_BR) || (kind == K_ST)) begin
      checkOutput($sformatf("%s.regwenPulses", name), 32'(regwCnt), 32'h0);
    end else begin
      checkOutput($sformatf("%s.regwenPulses", name), 32'(regwCnt), 32'h1);
      checkOutput($sformatf("%s.wbSel", name), 32'(wbObs), 32'(expWb));
      checkOutput($sformatf("%s.aluSel", name), 32'(aluObs), 32'(expAlu));
    end
    if (kind == K_BR) checkOutput($sformatf("%s.brUn", name), 32'(brUnObs), 32'(f3[1]));
    if (kind == K_LD) begin
      checkOutput($sformatf("%s.memRW", name), 32'(memRwMem), 32'h0);
      checkOutput($sformatf("%s.rSel", name), 32'(rselObs), 32'(f3));
    end
    if (kind == K_ST) begin
      checkOutput($sformatf("%s.memRW", name), 32'(memRwMem), 32'h1);
      checkOutput($sformatf("%s.wSel", name), 32'(wselObs), 32'(f3[1:0]));
    end
  endtask

  // Drives an instruction into a trap and checks when/why it trapped, then resets.
  task automatic applyTrapStimulus(input string name, input logic [31:0] ins,
                                   input logic ackFetch, input int expFirst,
                                   input int limitIdx, input logic [1:0] expCause);
    int cyc = 0, firstTrap = -1;
    logic reqAtLimit = 0, activity = 0, trapHeld = 1;
    logic [1:0] causeObs = 0;
    inst = ins;
    while ((firstTrap < 0) && (cyc < 80)) begin
      mem_ack = ackFetch && (cyc == 0);
      #4;
      if (cyc == limitIdx) reqAtLimit = mem_req;
      if (trap) begin firstTrap = cyc; causeObs = trap_cause; end
      cyc++;
      @(posedge clk);
      #1;
    end
    checkOutput($sformatf("%s.trapCycle", name), 32'(firstTrap), 32'(expFirst));
    checkOutput($sformatf("%s.trapCause", name), 32'(causeObs), 32'(expCause));
    if (limitIdx >= 0)
      checkOutput($sformatf("%s.reqAtLimit", name), 32'(reqAtLimit), 32'h1);
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1'($urandom_range(0, 1));
      #4;
      activity = activity | mem_req | IRWEn | PCWEn | RegWEn;
      trapHeld = trapHeld & trap;
      @(posedge clk);
      #1;
    end
    checkOutput($sformatf("%s.quietInTrap", name), 32'(activity), 32'h0);
    checkOutput($sformatf("%s.trapSticky", name), 32'(trapHeld), 32'h1);
    applyReset();
  endtask

  initial begin
    logic [31:0] illegalSet [5];
    int kind;
    checkCount = 0;
    errorCount = 0;
    inst    = 32'h0;
    BrEq    = 1'b0;
    BrLt    = 1'b0;
    mem_ack = 1'b0;
    rst_n   = 1'b1;
    #1;
    applyReset();

    applyStimulus("add", K_R, 32'h002081B3, 0, 0, 1'b0, 1'b0);
    applyStimulus("sub", K_R, 32'h402081B3, 0, 0, 1'b0, 1'b0);
    applyStimulus("lwWait3", K_LD, 32'h0000A183, 0, 3, 1'b0, 1'b0);
    applyStimulus("beqTaken", K_BR, 32'h00208463, 0, 0, 1'b1, 1'b0);
    applyStimulus("beqNotTaken", K_BR, 32'h00208463, 0, 0, 1'b0, 1'b1);
    applyStimulus("fetchAckAtLimit", K_R, 32'h002081B3, TB_TIMEOUT, 0, 1'b0, 1'b0);
    applyStimulus("swAckAtLimit", K_ST, 32'h0020A023, 1, TB_TIMEOUT, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 8));
      applyStimulus($sformatf("rand%0d", n), kind, genInst(kind),
                    int'($urandom_range(0, TB_TIMEOUT)), int'($urandom_range(0, TB_TIMEOUT)),
                    1'($urandom), 1'($urandom));
    end

    applyTrapStimulus("illegalOnes", 32'hFFFFFFFF, 1'b1, 2, -1, 2'd1);
    illegalSet = '{32'h0000B183, 32'h0020B023, 32'h0020A463, 32'h402091B3, 32'h0000000B};
    for (int i = 0; i < 5; i++)
      applyTrapStimulus($sformatf("illegal%0d", i), illegalSet[i], 1'b1, 2, -1, 2'd1);
    applyTrapStimulus("fetchTimeout", 32'h002081B3, 1'b0, TB_TIMEOUT + 1, TB_TIMEOUT, 2'd2);
    applyTrapStimulus("memTimeout", 32'h0000A183, 1'b1, TB_TIMEOUT + 4, TB_TIMEOUT + 3, 2'd3);

    mem_ack = 1'b0;
    @(posedge clk);
    #3;
    checkOutput("midReq.reqHeld", 32'(mem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("midReq.reqDropped", 32'(mem_req), 32'h0);
    applyReset();
    applyStimulus("addAfterReset", K_R, 32'h002081B3, 0, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
